// File: rtl/bram_port_arbiter_if.sv
// Bundle between the BRAM port arbiter, its burst requesters and the BRAM pins.
//   slave  : arbiter side (takes requests and read data, drives grants, beats and BRAM pins)
//   master : requesters plus BRAM side (drives requests, beat_valid and bram_out)
// Requester i owns slice i of req_addr, req_len and req_wdata.
interface bram_port_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned BRAM_DEPTH = 12,
    parameter int unsigned BRAM_WIDTH = 1152
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*BRAM_DEPTH-1:0] req_addr;
    logic [NUM_REQ*BRAM_DEPTH-1:0] req_len;
    logic [NUM_REQ*BRAM_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            beat_valid;
    logic [NUM_REQ-1:0]            beat_ready;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ-1:0]            rd_valid;
    logic [BRAM_WIDTH-1:0]         rd_data;
    logic                          busy;
    logic                          bram_clk;
    logic                          bram_en;
    logic                          bram_wen;
    logic [BRAM_DEPTH-1:0]         bram_addr;
    logic [BRAM_WIDTH-1:0]         bram_in;
    logic [BRAM_WIDTH-1:0]         bram_out;

    modport master (
        output req, req_we, req_addr, req_len, req_wdata, beat_valid, bram_out,
        input  beat_ready, grant, done, rd_valid, rd_data, busy,
        input  bram_clk, bram_en, bram_wen, bram_addr, bram_in
    );

    modport slave (
        input  req, req_we, req_addr, req_len, req_wdata, beat_valid, bram_out,
        output beat_ready, grant, done, rd_valid, rd_data, busy,
        output bram_clk, bram_en, bram_wen, bram_addr, bram_in
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between NUM_REQ burst requesters. Whole bursts are granted
// round-robin; beats are issued combinationally from registered burst state, read returns
// are tagged with the owner through a RD_LATENCY-deep one-hot pipeline, and burst
// completion is signalled with a one-cycle done pulse.
// Ports:
//   clk  : block clock, forwarded on bus.bram_clk
//   rstn : asynchronous active-low reset
//   bus  : requester handshakes and BRAM pins (slave modport)
module bram_port_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned BRAM_DEPTH = 12,
    parameter int unsigned BRAM_WIDTH = 1152,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rstn,
    bram_port_arbiter_if.slave bus
);
    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

    state_e                             r_state;
    state_e                             w_state_next;
    logic [NUM_REQ-1:0]                 r_grant;
    logic [NUM_REQ-1:0]                 r_done;
    logic                               r_we;
    logic                               r_abort;
    logic [BRAM_DEPTH-1:0]              r_addr;
    logic [BRAM_DEPTH-1:0]              r_remain;
    logic [PtrW-1:0]                    r_ptr;
    logic [RD_LATENCY-1:0][NUM_REQ-1:0] r_tag;

    logic                  w_any_req;
    logic                  w_issue;
    logic                  w_last;
    logic                  w_abort;
    logic                  w_tag_empty;
    int unsigned           w_idx;
    logic [NUM_REQ-1:0]    w_pick;
    logic [PtrW-1:0]       w_pick_ptr;
    logic                  w_pick_we;
    logic [BRAM_DEPTH-1:0] w_pick_addr;
    logic [BRAM_DEPTH-1:0] w_pick_len;
    logic [BRAM_WIDTH-1:0] w_wdata;

    assign w_any_req   = |bus.req;
    assign w_issue     = (r_state == StBurst) && (|(bus.req & bus.beat_valid & r_grant));
    assign w_last      = w_issue && (r_remain == '0);
    // Owner dropping its request mid-burst ends the burst without a done pulse.
    assign w_abort     = (r_state == StBurst) && !(|(bus.req & r_grant));
    assign w_tag_empty = (r_tag == '0);

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_idx       = 0;
        w_pick      = '0;
        w_pick_ptr  = '0;
        w_pick_we   = 1'b0;
        w_pick_addr = '0;
        w_pick_len  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if ((w_pick == '0) && bus.req[w_idx]) begin
                w_pick[w_idx] = 1'b1;
                w_pick_ptr    = PtrW'((w_idx + 1) % NUM_REQ);
                w_pick_we     = bus.req_we[w_idx];
                w_pick_addr   = bus.req_addr[w_idx*BRAM_DEPTH +: BRAM_DEPTH];
                w_pick_len    = bus.req_len[w_idx*BRAM_DEPTH +: BRAM_DEPTH];
            end
        end
    end

    always_comb begin
        w_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_wdata = bus.req_wdata[i*BRAM_WIDTH +: BRAM_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_any_req) w_state_next = StBurst;
            end
            StBurst: begin
                if (w_abort || w_last) w_state_next = r_we ? StIdle : StDrain;
            end
            StDrain: begin
                if (w_tag_empty) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Beat issue outputs: combinational from registered burst state, one beat per cycle.
    always_comb begin
        bus.beat_ready = '0;
        bus.bram_en    = 1'b0;
        bus.bram_wen   = 1'b0;
        bus.bram_addr  = '0;
        bus.bram_in    = '0;
        if (w_issue) begin
            bus.beat_ready = r_grant;
            bus.bram_en    = 1'b1;
            bus.bram_wen   = r_we;
            bus.bram_addr  = r_addr;
            bus.bram_in    = w_wdata;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.done     = r_done;
    assign bus.rd_valid = r_tag[RD_LATENCY-1];
    assign bus.rd_data  = bus.bram_out;
    assign bus.busy     = (r_state != StIdle);
    assign bus.bram_clk = clk;

    // Burst bookkeeping, pointer, done pulse and read-tag pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_grant  <= '0;
            r_done   <= '0;
            r_we     <= 1'b0;
            r_abort  <= 1'b0;
            r_addr   <= '0;
            r_remain <= '0;
            r_ptr    <= '0;
            r_tag    <= '0;
        end else begin
            r_done <= '0;
            for (int i = int'(RD_LATENCY) - 1; i > 0; i--) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_tag[0] <= (w_issue && !r_we) ? r_grant : '0;
            case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_grant  <= w_pick;
                        r_we     <= w_pick_we;
                        r_addr   <= w_pick_addr;
                        r_remain <= w_pick_len;
                        r_abort  <= 1'b0;
                        // Pointer moves past the winner now; nothing re-arbitrates until idle.
                        r_ptr    <= w_pick_ptr;
                    end
                end
                StBurst: begin
                    if (w_abort) begin
                        r_abort <= 1'b1;
                        if (r_we) r_grant <= '0;
                    end else if (w_issue) begin
                        r_addr   <= r_addr + 1'b1;
                        r_remain <= r_remain - 1'b1;
                        if (w_last && r_we) begin
                            r_done  <= r_grant;
                            r_grant <= '0;
                        end
                    end
                end
                StDrain: begin
                    if (w_tag_empty) begin
                        if (!r_abort) r_done <= r_grant;
                        r_grant <= '0;
                    end
                end
                default: r_grant <= '0;
            endcase
        end
    end
endmodule
